// File: rtl/axis_step_dir_driver.sv
// ---------------------------------------------------------------------------
// axis_step_dir_driver
//
// Purpose:
//   Converts the seeker's CW/CCW step requests into STEP/DIR pin activity for
//   an external stepper driver. The design guarantees DIR setup, STEP high and
//   STEP low times. Requests arriving faster than the driver can emit them
//   are held in a signed pending counter, which saturates at
//   +/-(2^(PENDING_W-1)-1).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset, clears all state
//   i_enable       1 = accept and emit steps, 0 = flush pending, start nothing
//   i_cw           seeker CW request, each rising level = +1 step
//   i_ccw          seeker CCW request, each rising level = -1 step
//   i_clear_flags  one-cycle pulse, clears o_overflow and o_conflict
//   o_step         STEP pin
//   o_dir          DIR pin (1 = CW, 0 = CCW)
//   o_busy         pending != 0 or a step sequence in progress
//   o_position     wrapping odometer of emitted steps (+1 CW, -1 CCW)
//   o_overflow     sticky: a request was dropped because pending saturated
//   o_conflict     sticky: CW and CCW rose in the same cycle
// ---------------------------------------------------------------------------
module axis_step_dir_driver #(
    parameter int DIR_SETUP_CYC  = 4,
    parameter int PULSE_HIGH_CYC = 3,
    parameter int PULSE_LOW_CYC  = 3,
    parameter int PENDING_W      = 8,
    parameter int POS_W          = 19
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_cw,
    input  logic             i_ccw,
    input  logic             i_clear_flags,
    output logic             o_step,
    output logic             o_dir,
    output logic             o_busy,
    output logic [POS_W-1:0] o_position,
    output logic             o_overflow,
    output logic             o_conflict
);

    localparam int MAX_A   = (DIR_SETUP_CYC > PULSE_HIGH_CYC) ? DIR_SETUP_CYC : PULSE_HIGH_CYC;
    localparam int MAX_CYC = (MAX_A > PULSE_LOW_CYC) ? MAX_A : PULSE_LOW_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] C_DIR  = CNT_W'(DIR_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_HIGH = CNT_W'(PULSE_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] C_LOW  = CNT_W'(PULSE_LOW_CYC - 1);

    // Pending arithmetic is done one bit wider so saturation can be detected.
    localparam logic signed [PENDING_W:0] P_ONE = {{PENDING_W{1'b0}}, 1'b1};
    localparam logic signed [PENDING_W:0] P_MAX = {2'b00, {(PENDING_W-1){1'b1}}};
    localparam logic signed [PENDING_W:0] P_MIN = -P_MAX;
    localparam logic [POS_W-1:0]          POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIR_SETUP,
        S_PULSE_HIGH,
        S_PULSE_LOW
    } state_t;

    state_t                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic                   r_step, w_step_next;
    logic                   r_dir, w_dir_next;
    logic [1:0]             r_in_q;
    logic signed [PENDING_W-1:0] r_pending, w_pending_next;
    logic [POS_W-1:0]       r_pos;
    logic                   r_ovf, r_cnf;

    logic [1:0]             w_in;
    logic [1:0]             w_rise;
    logic                   w_consume;
    logic                   w_need_cw;
    logic                   w_pend_nz;
    logic                   w_ovf_set;
    logic                   w_cnf_set;
    logic signed [PENDING_W:0] w_pend_ext, w_req, w_cons, w_base, w_sum;

    // Bit 0 = CW, bit 1 = CCW. Rises are masked while disabled.
    assign w_in = {i_ccw, i_cw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign w_rise[gi] = i_enable & w_in[gi] & ~r_in_q[gi];
        end
    endgenerate

    assign w_cnf_set = &w_rise;
    assign w_need_cw = ~r_pending[PENDING_W-1];
    assign w_pend_nz = |r_pending;

    // Step sequencer
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_step_next  = r_step;
        w_dir_next   = r_dir;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable && w_pend_nz) begin
                    if (w_need_cw != r_dir) begin
                        w_dir_next   = w_need_cw;
                        w_state_next = S_DIR_SETUP;
                        w_cnt_next   = C_DIR;
                    end else begin
                        w_state_next = S_PULSE_HIGH;
                        w_cnt_next   = C_HIGH;
                        w_step_next  = 1'b1;
                        w_consume    = 1'b1;
                    end
                end
            end
            S_DIR_SETUP: begin
                if (r_cnt == '0) begin
                    // Re-check at expiry: enable may have dropped or pending
                    // may have been cancelled while DIR was settling.
                    if (i_enable && w_pend_nz && (w_need_cw == r_dir)) begin
                        w_state_next = S_PULSE_HIGH;
                        w_cnt_next   = C_HIGH;
                        w_step_next  = 1'b1;
                        w_consume    = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PULSE_HIGH: begin
                if (r_cnt == '0) begin
                    w_state_next = S_PULSE_LOW;
                    w_cnt_next   = C_LOW;
                    w_step_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PULSE_LOW: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Pending counter: input request plus consume. A request that would push
    // the count past the limit is dropped, but the consume still applies.
    always_comb begin
        w_req = '0;
        if (w_rise == 2'b01) begin
            w_req = P_ONE;
        end else if (w_rise == 2'b10) begin
            w_req = -P_ONE;
        end
        w_cons = '0;
        if (w_consume) begin
            w_cons = r_dir ? -P_ONE : P_ONE;
        end
        w_pend_ext     = {r_pending[PENDING_W-1], r_pending};
        w_base         = w_pend_ext + w_cons;
        w_sum          = w_base + w_req;
        w_ovf_set      = 1'b0;
        w_pending_next = w_sum[PENDING_W-1:0];
        if ((w_sum > P_MAX) || (w_sum < P_MIN)) begin
            w_ovf_set      = 1'b1;
            w_pending_next = w_base[PENDING_W-1:0];
        end
        if ((r_state == S_IDLE) && !i_enable) begin
            w_pending_next = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_step    <= 1'b0;
            r_dir     <= 1'b1;
            r_in_q    <= '0;
            r_pending <= '0;
            r_pos     <= '0;
            r_ovf     <= 1'b0;
            r_cnf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_step    <= w_step_next;
            r_dir     <= w_dir_next;
            r_in_q    <= w_in;
            r_pending <= w_pending_next;
            if (w_consume) begin
                r_pos <= r_dir ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
            end
            // A new flag event wins over a simultaneous clear.
            r_ovf <= w_ovf_set | (r_ovf & ~i_clear_flags);
            r_cnf <= w_cnf_set | (r_cnf & ~i_clear_flags);
        end
    end

    assign o_step     = r_step;
    assign o_dir      = r_dir;
    assign o_busy     = w_pend_nz | (r_state != S_IDLE);
    assign o_position = r_pos;
    assign o_overflow = r_ovf;
    assign o_conflict = r_cnf;

endmodule

// File: tb/tb_axis_step_dir_driver.sv
module tb_axis_step_dir_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, cw, ccw, clr;
    logic        step, dir, busy, ovf, cnf;
    logic [18:0] pos;

    axis_step_dir_driver dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_cw          (cw),
        .i_ccw         (ccw),
        .i_clear_flags (clr),
        .o_step        (step),
        .o_dir         (dir),
        .o_busy        (busy),
        .o_position    (pos),
        .o_overflow    (ovf),
        .o_conflict    (cnf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected pulse directions are pushed when a request is
    // driven and popped when the DUT raises STEP.
    bit   sb_q[$];
    bit   sb_en = 1'b1;
    int   pulse_cnt = 0;
    int   cyc = 0;
    int   rise_cyc[$];
    logic prev_step = 1'b0;
    int   hi_len = 0;

    always @(negedge clk) begin
        cyc++;
        if (step === 1'b1 && prev_step === 1'b0) begin
            pulse_cnt++;
            rise_cyc.push_back(cyc);
            hi_len = 1;
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_pulse actual=pulse required=none");
                end else begin
                    chk("sb_dir", dir, sb_q.pop_front());
                end
            end
        end else if (step === 1'b1) begin
            hi_len++;
        end
        if (step === 1'b0 && prev_step === 1'b1 && sb_en)
            chk("pulse_high_len", hi_len, 3);
        prev_step = step;
    end

    typedef struct {
        bit          en, cw, ccw, clr;
        bit          step, dir, busy;
        logic [18:0] pos;
        bit          ovf, cnf;
        int          push;   // 0 none, 1 expect CW pulse, 2 expect CCW pulse
    } vec_t;

    function automatic vec_t mk(bit c, bit cc, bit cl, bit s, bit d, bit b,
                                logic [18:0] p, bit cf, int pu);
        vec_t v;
        v.en = 1'b1; v.cw = c; v.ccw = cc; v.clr = cl;
        v.step = s; v.dir = d; v.busy = b; v.pos = p;
        v.ovf = 1'b0; v.cnf = cf; v.push = pu;
        return v;
    endfunction

    vec_t tbl[32];

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        logic [18:0] exp_pos;
        int p0, p_end, total, d;

        rst_n = 1'b0; en = 1'b0; cw = 1'b0; ccw = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pos", pos, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnf", cnf, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);

        // Cycle-exact table: CW step, CCW reversal with DIR setup, CCW wrap to
        // -1, conflict and flag clearing (set wins over clear).
        //            cw ccw clr  step dir busy pos       cnf push
        tbl[0]  = mk(1, 0, 0,    0, 1, 1, 19'd0,     0, 1);
        tbl[1]  = mk(0, 0, 0,    1, 1, 1, 19'd1,     0, 0);
        tbl[2]  = mk(0, 0, 0,    1, 1, 1, 19'd1,     0, 0);
        tbl[3]  = mk(0, 0, 0,    1, 1, 1, 19'd1,     0, 0);
        tbl[4]  = mk(0, 0, 0,    0, 1, 1, 19'd1,     0, 0);
        tbl[5]  = mk(0, 0, 0,    0, 1, 1, 19'd1,     0, 0);
        tbl[6]  = mk(0, 0, 0,    0, 1, 1, 19'd1,     0, 0);
        tbl[7]  = mk(0, 0, 0,    0, 1, 0, 19'd1,     0, 0);
        tbl[8]  = mk(0, 1, 0,    0, 1, 1, 19'd1,     0, 2);
        tbl[9]  = mk(0, 0, 0,    0, 0, 1, 19'd1,     0, 0);
        tbl[10] = mk(0, 0, 0,    0, 0, 1, 19'd1,     0, 0);
        tbl[11] = mk(0, 0, 0,    0, 0, 1, 19'd1,     0, 0);
        tbl[12] = mk(0, 0, 0,    0, 0, 1, 19'd1,     0, 0);
        tbl[13] = mk(0, 0, 0,    1, 0, 1, 19'd0,     0, 0);
        tbl[14] = mk(0, 0, 0,    1, 0, 1, 19'd0,     0, 0);
        tbl[15] = mk(0, 0, 0,    1, 0, 1, 19'd0,     0, 0);
        tbl[16] = mk(0, 0, 0,    0, 0, 1, 19'd0,     0, 0);
        tbl[17] = mk(0, 0, 0,    0, 0, 1, 19'd0,     0, 0);
        tbl[18] = mk(0, 0, 0,    0, 0, 1, 19'd0,     0, 0);
        tbl[19] = mk(0, 0, 0,    0, 0, 0, 19'd0,     0, 0);
        tbl[20] = mk(0, 1, 0,    0, 0, 1, 19'd0,     0, 2);
        tbl[21] = mk(0, 0, 0,    1, 0, 1, 19'h7FFFF, 0, 0);
        tbl[22] = mk(0, 0, 0,    1, 0, 1, 19'h7FFFF, 0, 0);
        tbl[23] = mk(0, 0, 0,    1, 0, 1, 19'h7FFFF, 0, 0);
        tbl[24] = mk(0, 0, 0,    0, 0, 1, 19'h7FFFF, 0, 0);
        tbl[25] = mk(0, 0, 0,    0, 0, 1, 19'h7FFFF, 0, 0);
        tbl[26] = mk(0, 0, 0,    0, 0, 1, 19'h7FFFF, 0, 0);
        tbl[27] = mk(0, 0, 0,    0, 0, 0, 19'h7FFFF, 0, 0);
        tbl[28] = mk(1, 1, 0,    0, 0, 0, 19'h7FFFF, 1, 0);
        tbl[29] = mk(0, 0, 1,    0, 0, 0, 19'h7FFFF, 0, 0);
        tbl[30] = mk(1, 1, 1,    0, 0, 0, 19'h7FFFF, 1, 0);
        tbl[31] = mk(0, 0, 1,    0, 0, 0, 19'h7FFFF, 0, 0);

        for (int i = 0; i < 32; i++) begin
            en = tbl[i].en; cw = tbl[i].cw; ccw = tbl[i].ccw; clr = tbl[i].clr;
            if (tbl[i].push == 1) sb_q.push_back(1'b1);
            if (tbl[i].push == 2) sb_q.push_back(1'b0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_step", i), step, tbl[i].step);
            chk($sformatf("tbl%0d_dir", i), dir, tbl[i].dir);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_pos", i), pos, tbl[i].pos);
            chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
            chk($sformatf("tbl%0d_cnf", i), cnf, tbl[i].cnf);
        end
        cw = 1'b0; ccw = 1'b0; clr = 1'b0;
        exp_pos = 19'h7FFFF;

        // Burst of 5 CW requests every 2 cycles: 5 pulses, period 7.
        rise_cyc.delete();
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back(1'b1);
            cw = 1'b1; @(negedge clk);
            cw = 1'b0; @(negedge clk);
        end
        wait_idle("burst_drain", 200);
        exp_pos = exp_pos + 19'd5;
        chk("burst_pos", pos, exp_pos);
        chk("burst_ovf", ovf, 0);
        chk("burst_pulse_count", rise_cyc.size(), 5);
        for (int k = 1; k < rise_cyc.size(); k++)
            chk($sformatf("burst_period%0d", k), rise_cyc[k] - rise_cyc[k-1], 7);

        // Overflow: 300 requests outrun the driver and saturate pending.
        sb_en = 1'b0;
        p0 = pulse_cnt;
        p_end = 0;
        for (int k = 0; k < 300; k++) begin
            cw = 1'b1; @(negedge clk);
            if (k == 299) begin
                #1;
                p_end = pulse_cnt - p0;
            end
            cw = 1'b0; @(negedge clk);
        end
        chk("ovf_set", ovf, 1);
        wait_idle("ovf_drain", 2000);
        #1;
        total = pulse_cnt - p0;
        d = total - p_end;
        chk("ovf_residual_saturated", (d == 126 || d == 127), 1);
        exp_pos = exp_pos + 19'(total);
        chk("ovf_pos", pos, exp_pos);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        chk("ovf_clear", ovf, 0);

        // Reset in the middle of a high pulse.
        cw = 1'b1; @(negedge clk); cw = 1'b0;
        for (int n = 0; n < 20 && step !== 1'b1; n++) @(negedge clk);
        chk("midpulse_step_high", step, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midpulse_rst_step", step, 0);
        chk("midpulse_rst_pos", pos, 0);
        chk("midpulse_rst_busy", busy, 0);
        chk("midpulse_rst_dir", dir, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 p0 = pulse_cnt;
        repeat (20) @(negedge clk);
        #1;
        chk("midpulse_lost_pulses", pulse_cnt - p0, 0);

        // Enable dropped with 3 CCW requests pending during DIR setup.
        sb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ccw = 1'b1; @(negedge clk);
            if (k < 2) begin
                ccw = 1'b0; @(negedge clk);
            end
        end
        ccw = 1'b0;
        en  = 1'b0;
        chk("dis_busy_pending", busy, 1);
        #1 p0 = pulse_cnt;
        repeat (30) @(negedge clk);
        #1;
        chk("dis_no_pulses", pulse_cnt - p0, 0);
        chk("dis_busy_flushed", busy, 0);
        chk("dis_pos", pos, 0);

        chk("sb_leftover", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
